ddr3_rd_arb: RTL and testbench
==============================

DDR3_RD_ARB -- requirements
Module: ddr3_rd_arb

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-002 SHALL have `rstn`, input, 1 bit: asynchronous active-low reset; it is synchronized internally through a `rstn_sync` instance.
REQ-003 SHALL have `Mn_RD_ADDR_ID` / `Mn_RD_ADDR` / `Mn_RD_ADDR_LEN` / `Mn_RD_ADDR_BURST`, inputs, 4/28/8/2 bits (n=0,1): master n read address.
REQ-004 SHALL have `Mn_RD_ADDR_VALID`, input, 1 bit, and `Mn_RD_ADDR_READY`, output, 1 bit: master n address handshake.
REQ-005 SHALL have `Mn_RD_BACK_ID` / `Mn_RD_DATA` / `Mn_RD_DATA_RESP` / `Mn_RD_DATA_LAST`, outputs, 4/32/2/1 bits: master n read data.
REQ-006 SHALL have `Mn_RD_DATA_VALID`, output, 1 bit, and `Mn_RD_DATA_READY`, input, 1 bit: master n data handshake.
REQ-007 SHALL have `S_RD_ADDR_ID` / `S_RD_ADDR` / `S_RD_ADDR_LEN` / `S_RD_ADDR_BURST` / `S_RD_ADDR_VALID`, outputs, 4/28/8/2/1 bits, and `S_RD_ADDR_READY`, input, 1 bit: address channel to the DDR3 read converter.
REQ-008 SHALL have `S_RD_BACK_ID` / `S_RD_DATA` / `S_RD_DATA_RESP` / `S_RD_DATA_LAST` / `S_RD_DATA_VALID`, inputs, 4/32/2/1/1 bits, and `S_RD_DATA_READY`, output, 1 bit: data channel from the DDR3 read converter.

Function
REQ-009 SHALL implement the states IDLE, ADDR and DATA, holding at most one outstanding transaction.
REQ-010 In IDLE, SHALL select a master combinationally: the only requester wins; if both request, the master named by priority pointer `rr_ptr` wins.
REQ-011 In IDLE, SHALL assert `Mn_RD_ADDR_READY` only for the selected master, and assert it in the same cycle as that master's VALID.
REQ-012 On a master address handshake, SHALL register ID, address, LEN, BURST and the grant bit `gnt`, load `beat_cnt` with LEN, and go to ADDR.
REQ-013 In ADDR, SHALL drive `S_RD_ADDR_VALID`=1 with the registered fields held stable, and go to DATA on `S_RD_ADDR_READY`.
REQ-014 In DATA, SHALL route `S_RD_DATA_VALID`, data, RESP, LAST and BACK_ID only to master `gnt`, and take `S_RD_DATA_READY` from `Mn_RD_DATA_READY` of that master only.
REQ-015 In DATA, the non-granted master's `DATA_VALID` SHALL be 0.
REQ-016 SHALL decrement `beat_cnt` on each data handshake, saturating at 0.
REQ-017 On a handshake with LAST=1, SHALL go to IDLE and set `rr_ptr` to the opposite of `gnt`; the earliest next grant is the following cycle.
REQ-018 If LAST arrives while `beat_cnt`≠0, or `beat_cnt`=0 is reached without LAST, SHALL force RESP=2'b10 on that beat; otherwise RESP passes through unchanged.
REQ-019 Data beats arriving in IDLE or ADDR SHALL be ignored, with `S_RD_DATA_READY`=0.
REQ-020 `S_RD_DATA_READY` SHALL be 0 outside DATA.
REQ-021 Address/data latency: the `S_RD_ADDR_VALID` rising edge follows the master handshake by exactly 1 cycle; the data path is 0-cycle combinational.

Reset
REQ-022 When synchronized `rstn` is low, SHALL force the state to IDLE, `rr_ptr`=0, `gnt`=0, `beat_cnt`=0, all registered fields 0, and every VALID/READY/LAST output 0.
REQ-023 A reset asserted mid-transaction SHALL abandon the transaction without any further handshake toward either side.

Configuration
REQ-024 With `DDR3_RD_ARB_FIXED_PRIO_EN` defined, master 0 SHALL always win simultaneous requests and `rr_ptr` is not implemented.
REQ-025 Without `DDR3_RD_ARB_FIXED_PRIO_EN`, SHALL use the round-robin behaviour of REQ-010 and REQ-017.

Verification
REQ-026 SHALL cover: M0 alone, ADDR=0x0000010, LEN=3 -> `S_RD_ADDR_VALID` one cycle after the handshake; 4 beats to M0 with LAST on beat 4; M1 sees no VALID.
REQ-027 SHALL cover: both request after reset -> M0 granted first, M1 second, then M0 again (round-robin); with the macro defined, M0 wins every time.
REQ-028 SHALL cover: `S_RD_ADDR_READY` held low 5 cycles -> address fields stable, `Mn_RD_ADDR_READY`=0 for both masters throughout.
REQ-029 SHALL cover: LEN=7 with LAST on beat 5 -> RESP=2'b10 on beat 5, return to IDLE.
REQ-030 SHALL cover: granted master drops `DATA_READY` 3 cycles mid-burst -> `S_RD_DATA_READY`=0 for 3 cycles, no beat lost or duplicated.
REQ-031 SHALL cover: `rstn` pulsed low during DATA beat 2 of 8 -> all outputs 0 within the reset; after release, a new M1 request is granted normally.

Source files
------------

// File: rtl/ddr3_rd_arb.sv
// rtl/ddr3_rd_arb.sv - two-master read arbiter in front of the DDR3 read converter (option: DDR3_RD_ARB_FIXED_PRIO_EN)

module rstn_sync (
  input  logic clk,
  input  logic i_rstn,
  output logic o_rstn
);
  logic [1:0] r_sync;

  // assert immediately, release after two clean clock edges
  always_ff @(posedge clk or negedge i_rstn) begin
    if (!i_rstn) r_sync <= 2'b00;
    else         r_sync <= {r_sync[0], 1'b1};
  end

  assign o_rstn = r_sync[1];
endmodule

module ddr3_rd_arb (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  M0_RD_ADDR_ID,
  input  logic [27:0] M0_RD_ADDR,
  input  logic [7:0]  M0_RD_ADDR_LEN,
  input  logic [1:0]  M0_RD_ADDR_BURST,
  input  logic        M0_RD_ADDR_VALID,
  output logic        M0_RD_ADDR_READY,
  output logic [3:0]  M0_RD_BACK_ID,
  output logic [31:0] M0_RD_DATA,
  output logic [1:0]  M0_RD_DATA_RESP,
  output logic        M0_RD_DATA_LAST,
  output logic        M0_RD_DATA_VALID,
  input  logic        M0_RD_DATA_READY,
  input  logic [3:0]  M1_RD_ADDR_ID,
  input  logic [27:0] M1_RD_ADDR,
  input  logic [7:0]  M1_RD_ADDR_LEN,
  input  logic [1:0]  M1_RD_ADDR_BURST,
  input  logic        M1_RD_ADDR_VALID,
  output logic        M1_RD_ADDR_READY,
  output logic [3:0]  M1_RD_BACK_ID,
  output logic [31:0] M1_RD_DATA,
  output logic [1:0]  M1_RD_DATA_RESP,
  output logic        M1_RD_DATA_LAST,
  output logic        M1_RD_DATA_VALID,
  input  logic        M1_RD_DATA_READY,
  output logic [3:0]  S_RD_ADDR_ID,
  output logic [27:0] S_RD_ADDR,
  output logic [7:0]  S_RD_ADDR_LEN,
  output logic [1:0]  S_RD_ADDR_BURST,
  output logic        S_RD_ADDR_VALID,
  input  logic        S_RD_ADDR_READY,
  input  logic [3:0]  S_RD_BACK_ID,
  input  logic [31:0] S_RD_DATA,
  input  logic [1:0]  S_RD_DATA_RESP,
  input  logic        S_RD_DATA_LAST,
  input  logic        S_RD_DATA_VALID,
  output logic        S_RD_DATA_READY
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_DATA = 2'd2} state_t;

  state_t      r_state, w_state_nxt;
  logic        w_rstn;
  logic        w_req, w_sel, w_addr_hs, w_dat_hs, w_s_rdy;
  logic        w_to_m0, w_to_m1, w_resp_err;
  logic [1:0]  w_resp;
  logic [3:0]  r_id;
  logic [27:0] r_addr;
  logic [7:0]  r_len, r_beat_cnt;
  logic [1:0]  r_burst;
  logic        r_gnt;

  rstn_sync u_rstn_sync (
    .clk    (clk),
    .i_rstn (rstn),
    .o_rstn (w_rstn)
  );

  assign w_req = M0_RD_ADDR_VALID | M1_RD_ADDR_VALID;

`ifdef DDR3_RD_ARB_FIXED_PRIO_EN
  // master 0 wins any tie; master 1 only when alone
  assign w_sel = ~M0_RD_ADDR_VALID;
`else
  logic r_rr_ptr;

  // a tie goes to r_rr_ptr; a lone requester always wins
  assign w_sel = (M0_RD_ADDR_VALID && M1_RD_ADDR_VALID) ? r_rr_ptr : ~M0_RD_ADDR_VALID;

  // hand priority to the other master once a burst completes
  always_ff @(posedge clk or negedge w_rstn) begin
    if (!w_rstn)                          r_rr_ptr <= 1'b0;
    else if (w_dat_hs && S_RD_DATA_LAST)  r_rr_ptr <= ~r_gnt;
  end
`endif

  // readies are held low while the synchronized reset is active
  assign w_addr_hs = (r_state == ST_IDLE) && w_req && w_rstn;
  assign w_s_rdy   = r_gnt ? M1_RD_DATA_READY : M0_RD_DATA_READY;
  assign w_dat_hs  = (r_state == ST_DATA) && S_RD_DATA_VALID && w_s_rdy;

  // state register
  always_ff @(posedge clk or negedge w_rstn) begin
    if (!w_rstn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // next state and handshake readies
  always_comb begin
    w_state_nxt      = r_state;
    M0_RD_ADDR_READY = 1'b0;
    M1_RD_ADDR_READY = 1'b0;
    S_RD_DATA_READY  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_addr_hs) begin
          M0_RD_ADDR_READY = ~w_sel;
          M1_RD_ADDR_READY = w_sel;
          w_state_nxt      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (S_RD_ADDR_READY) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        S_RD_DATA_READY = w_s_rdy;
        if (w_dat_hs && S_RD_DATA_LAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // capture the winning request and count down the expected beats
  always_ff @(posedge clk or negedge w_rstn) begin
    if (!w_rstn) begin
      r_id       <= 4'd0;
      r_addr     <= 28'd0;
      r_len      <= 8'd0;
      r_burst    <= 2'd0;
      r_gnt      <= 1'b0;
      r_beat_cnt <= 8'd0;
    end else if (w_addr_hs) begin
      r_id       <= w_sel ? M1_RD_ADDR_ID    : M0_RD_ADDR_ID;
      r_addr     <= w_sel ? M1_RD_ADDR       : M0_RD_ADDR;
      r_len      <= w_sel ? M1_RD_ADDR_LEN   : M0_RD_ADDR_LEN;
      r_burst    <= w_sel ? M1_RD_ADDR_BURST : M0_RD_ADDR_BURST;
      r_gnt      <= w_sel;
      r_beat_cnt <= w_sel ? M1_RD_ADDR_LEN   : M0_RD_ADDR_LEN;
    end else if (w_dat_hs && (r_beat_cnt != 8'd0)) begin
      r_beat_cnt <= r_beat_cnt - 8'd1;
    end
  end

  assign S_RD_ADDR_VALID = (r_state == ST_ADDR);
  assign S_RD_ADDR_ID    = r_id;
  assign S_RD_ADDR       = r_addr;
  assign S_RD_ADDR_LEN   = r_len;
  assign S_RD_ADDR_BURST = r_burst;

  // a burst whose LAST disagrees with its LEN is flagged SLVERR on the offending beat
  assign w_resp_err = S_RD_DATA_LAST ? (r_beat_cnt != 8'd0) : (r_beat_cnt == 8'd0);
  assign w_resp     = w_resp_err ? 2'b10 : S_RD_DATA_RESP;

  assign w_to_m0 = (r_state == ST_DATA) && !r_gnt;
  assign w_to_m1 = (r_state == ST_DATA) &&  r_gnt;

  assign M0_RD_DATA_VALID = w_to_m0 & S_RD_DATA_VALID;
  assign M0_RD_DATA_LAST  = w_to_m0 & S_RD_DATA_LAST;
  assign M0_RD_DATA       = w_to_m0 ? S_RD_DATA    : 32'd0;
  assign M0_RD_BACK_ID    = w_to_m0 ? S_RD_BACK_ID : 4'd0;
  assign M0_RD_DATA_RESP  = w_to_m0 ? w_resp       : 2'd0;

  assign M1_RD_DATA_VALID = w_to_m1 & S_RD_DATA_VALID;
  assign M1_RD_DATA_LAST  = w_to_m1 & S_RD_DATA_LAST;
  assign M1_RD_DATA       = w_to_m1 ? S_RD_DATA    : 32'd0;
  assign M1_RD_BACK_ID    = w_to_m1 ? S_RD_BACK_ID : 4'd0;
  assign M1_RD_DATA_RESP  = w_to_m1 ? w_resp       : 2'd0;
endmodule

// File: tb/tb_ddr3_rd_arb.sv
// tb/tb_ddr3_rd_arb.sv - scoreboard bench for ddr3_rd_arb

module tb_ddr3_rd_arb;
  logic        clk, rstn;
  logic [3:0]  M0_RD_ADDR_ID, M1_RD_ADDR_ID, M0_RD_BACK_ID, M1_RD_BACK_ID;
  logic [27:0] M0_RD_ADDR, M1_RD_ADDR;
  logic [7:0]  M0_RD_ADDR_LEN, M1_RD_ADDR_LEN;
  logic [1:0]  M0_RD_ADDR_BURST, M1_RD_ADDR_BURST;
  logic        M0_RD_ADDR_VALID, M0_RD_ADDR_READY, M1_RD_ADDR_VALID, M1_RD_ADDR_READY;
  logic [31:0] M0_RD_DATA, M1_RD_DATA;
  logic [1:0]  M0_RD_DATA_RESP, M1_RD_DATA_RESP;
  logic        M0_RD_DATA_LAST, M0_RD_DATA_VALID, M0_RD_DATA_READY;
  logic        M1_RD_DATA_LAST, M1_RD_DATA_VALID, M1_RD_DATA_READY;
  logic [3:0]  S_RD_ADDR_ID, S_RD_BACK_ID;
  logic [27:0] S_RD_ADDR;
  logic [7:0]  S_RD_ADDR_LEN;
  logic [1:0]  S_RD_ADDR_BURST, S_RD_DATA_RESP;
  logic        S_RD_ADDR_VALID, S_RD_ADDR_READY;
  logic [31:0] S_RD_DATA;
  logic        S_RD_DATA_LAST, S_RD_DATA_VALID, S_RD_DATA_READY;

  ddr3_rd_arb dut (
    .clk(clk), .rstn(rstn),
    .M0_RD_ADDR_ID(M0_RD_ADDR_ID), .M0_RD_ADDR(M0_RD_ADDR), .M0_RD_ADDR_LEN(M0_RD_ADDR_LEN),
    .M0_RD_ADDR_BURST(M0_RD_ADDR_BURST), .M0_RD_ADDR_VALID(M0_RD_ADDR_VALID), .M0_RD_ADDR_READY(M0_RD_ADDR_READY),
    .M0_RD_BACK_ID(M0_RD_BACK_ID), .M0_RD_DATA(M0_RD_DATA), .M0_RD_DATA_RESP(M0_RD_DATA_RESP),
    .M0_RD_DATA_LAST(M0_RD_DATA_LAST), .M0_RD_DATA_VALID(M0_RD_DATA_VALID), .M0_RD_DATA_READY(M0_RD_DATA_READY),
    .M1_RD_ADDR_ID(M1_RD_ADDR_ID), .M1_RD_ADDR(M1_RD_ADDR), .M1_RD_ADDR_LEN(M1_RD_ADDR_LEN),
    .M1_RD_ADDR_BURST(M1_RD_ADDR_BURST), .M1_RD_ADDR_VALID(M1_RD_ADDR_VALID), .M1_RD_ADDR_READY(M1_RD_ADDR_READY),
    .M1_RD_BACK_ID(M1_RD_BACK_ID), .M1_RD_DATA(M1_RD_DATA), .M1_RD_DATA_RESP(M1_RD_DATA_RESP),
    .M1_RD_DATA_LAST(M1_RD_DATA_LAST), .M1_RD_DATA_VALID(M1_RD_DATA_VALID), .M1_RD_DATA_READY(M1_RD_DATA_READY),
    .S_RD_ADDR_ID(S_RD_ADDR_ID), .S_RD_ADDR(S_RD_ADDR), .S_RD_ADDR_LEN(S_RD_ADDR_LEN),
    .S_RD_ADDR_BURST(S_RD_ADDR_BURST), .S_RD_ADDR_VALID(S_RD_ADDR_VALID), .S_RD_ADDR_READY(S_RD_ADDR_READY),
    .S_RD_BACK_ID(S_RD_BACK_ID), .S_RD_DATA(S_RD_DATA), .S_RD_DATA_RESP(S_RD_DATA_RESP),
    .S_RD_DATA_LAST(S_RD_DATA_LAST), .S_RD_DATA_VALID(S_RD_DATA_VALID), .S_RD_DATA_READY(S_RD_DATA_READY)
  );

  typedef logic [38:0] beat_t;   // {id, data, resp, last}
  beat_t       q0[$], q1[$];
  logic [41:0] exp_addr[$];      // {id, addr, len, burst}
  int          exp_gnt[$];
  int          total = 0, bad = 0;
  int          cyc = 0, hs_cyc = 0, m0_beats = 0, m1_vcnt = 0, stall_cnt = 0;
  logic        prev_sav = 0, prev_hs = 0;
  logic [41:0] prev_fields = '0;
  int          ord[4];
  logic [3:0]  ids[4];
  logic [27:0] ads[4];
  logic [7:0]  lens[4];
  int          snap_a, snap_b;
  bit          trig_ok;

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic m_req(input int m, input logic [3:0] id, input logic [27:0] a,
                       input logic [7:0] l, input logic [1:0] b);
    bit ok = 0;
    if (m == 0) begin
      M0_RD_ADDR_ID = id; M0_RD_ADDR = a; M0_RD_ADDR_LEN = l; M0_RD_ADDR_BURST = b; M0_RD_ADDR_VALID = 1;
    end else begin
      M1_RD_ADDR_ID = id; M1_RD_ADDR = a; M1_RD_ADDR_LEN = l; M1_RD_ADDR_BURST = b; M1_RD_ADDR_VALID = 1;
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((m == 0 && M0_RD_ADDR_READY) || (m == 1 && M1_RD_ADDR_READY)) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    if (m == 0) M0_RD_ADDR_VALID = 0; else M1_RD_ADDR_VALID = 0;
    chk("m_req_granted", ok, 1);
  endtask

  task automatic s_addr(input int hold);
    bit ok = 0;
    int cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (S_RD_ADDR_VALID) begin
        cnt++;
        if (cnt >= hold) begin ok = 1; break; end
      end
    end
    @(posedge clk); #1 S_RD_ADDR_READY = 1;
    @(posedge clk); #1 S_RD_ADDR_READY = 0;
    chk("s_addr_seen", ok, 1);
  endtask

  task automatic s_data(input int nb, input int last_at, input int m, input logic [3:0] id,
                        input logic [31:0] base, input logic [1:0] resp, input int err_beat);
    beat_t e;
    bit ok;
    for (int i = 1; i <= nb; i++) begin
      e = {id, base + 32'(i), (i == err_beat) ? 2'b10 : resp, 1'(i == last_at)};
      if (m == 0) q0.push_back(e); else q1.push_back(e);
      S_RD_BACK_ID = id; S_RD_DATA = base + 32'(i); S_RD_DATA_RESP = resp;
      S_RD_DATA_LAST = (i == last_at); S_RD_DATA_VALID = 1;
      ok = 0;
      for (int j = 0; j < 300; j++) begin
        @(negedge clk);
        if (S_RD_DATA_READY) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      chk("s_beat_taken", ok, 1);
    end
    S_RD_DATA_VALID = 0; S_RD_DATA_LAST = 0;
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a handshake
  always @(negedge clk) begin
    cyc++;
    if (M0_RD_ADDR_VALID && M0_RD_ADDR_READY) begin
      chk("gnt_expected", exp_gnt.size() != 0, 1);
      if (exp_gnt.size() != 0) chk("gnt_m0", 0, exp_gnt.pop_front());
      hs_cyc = cyc;
    end
    if (M1_RD_ADDR_VALID && M1_RD_ADDR_READY) begin
      chk("gnt_expected", exp_gnt.size() != 0, 1);
      if (exp_gnt.size() != 0) chk("gnt_m1", 1, exp_gnt.pop_front());
      hs_cyc = cyc;
    end
    if (S_RD_ADDR_VALID && !prev_sav) chk("addr_latency", cyc - hs_cyc, 1);
    if (S_RD_ADDR_VALID) begin
      chk("mrdy_in_addr", {M0_RD_ADDR_READY, M1_RD_ADDR_READY}, 0);
      if (prev_sav && !prev_hs)
        chk("addr_stable", {S_RD_ADDR_ID, S_RD_ADDR, S_RD_ADDR_LEN, S_RD_ADDR_BURST}, prev_fields);
    end
    if (S_RD_ADDR_VALID && S_RD_ADDR_READY) begin
      chk("addr_expected", exp_addr.size() != 0, 1);
      if (exp_addr.size() != 0)
        chk("addr_fields", {S_RD_ADDR_ID, S_RD_ADDR, S_RD_ADDR_LEN, S_RD_ADDR_BURST}, exp_addr.pop_front());
    end
    prev_sav    = S_RD_ADDR_VALID;
    prev_hs     = S_RD_ADDR_VALID && S_RD_ADDR_READY;
    prev_fields = {S_RD_ADDR_ID, S_RD_ADDR, S_RD_ADDR_LEN, S_RD_ADDR_BURST};
    if (M0_RD_DATA_VALID && M0_RD_DATA_READY) begin
      chk("m0_beat_expected", q0.size() != 0, 1);
      if (q0.size() != 0)
        chk("m0_beat", {M0_RD_BACK_ID, M0_RD_DATA, M0_RD_DATA_RESP, M0_RD_DATA_LAST}, q0.pop_front());
      m0_beats++;
    end
    if (M1_RD_DATA_VALID && M1_RD_DATA_READY) begin
      chk("m1_beat_expected", q1.size() != 0, 1);
      if (q1.size() != 0)
        chk("m1_beat", {M1_RD_BACK_ID, M1_RD_DATA, M1_RD_DATA_RESP, M1_RD_DATA_LAST}, q1.pop_front());
    end
    if (M1_RD_DATA_VALID) m1_vcnt++;
    if (S_RD_DATA_VALID && !S_RD_DATA_READY && M0_RD_DATA_VALID) stall_cnt++;
  end

  initial begin
    rstn = 0;
    M0_RD_ADDR_ID = 0; M0_RD_ADDR = 0; M0_RD_ADDR_LEN = 0; M0_RD_ADDR_BURST = 0; M0_RD_ADDR_VALID = 0;
    M1_RD_ADDR_ID = 0; M1_RD_ADDR = 0; M1_RD_ADDR_LEN = 0; M1_RD_ADDR_BURST = 0; M1_RD_ADDR_VALID = 0;
    M0_RD_DATA_READY = 1; M1_RD_DATA_READY = 1;
    S_RD_ADDR_READY = 0; S_RD_BACK_ID = 0; S_RD_DATA = 0; S_RD_DATA_RESP = 0;
    S_RD_DATA_LAST = 0; S_RD_DATA_VALID = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_ctrl", {S_RD_ADDR_VALID, S_RD_DATA_READY, M0_RD_ADDR_READY, M1_RD_ADDR_READY,
                     M0_RD_DATA_VALID, M1_RD_DATA_VALID, M0_RD_DATA_LAST, M1_RD_DATA_LAST}, 0);
    chk("rst_fields", {S_RD_ADDR_ID, S_RD_ADDR, S_RD_ADDR_LEN, S_RD_ADDR_BURST}, 0);
    rstn = 1;
    repeat (3) @(posedge clk); #1;

    // simultaneous requests straight out of reset
`ifdef DDR3_RD_ARB_FIXED_PRIO_EN
    ord = '{0, 0, 1, 1}; ids = '{4'h1, 4'h2, 4'h9, 4'hA};
    ads = '{28'h100, 28'h200, 28'h900, 28'hA00}; lens = '{8'd0, 8'd0, 8'd1, 8'd0};
`else
    ord = '{0, 1, 0, 1}; ids = '{4'h1, 4'h9, 4'h2, 4'hA};
    ads = '{28'h100, 28'h900, 28'h200, 28'hA00}; lens = '{8'd0, 8'd1, 8'd0, 8'd0};
`endif
    for (int k = 0; k < 4; k++) begin
      exp_gnt.push_back(ord[k]);
      exp_addr.push_back({ids[k], ads[k], lens[k], 2'b01});
    end
    fork
      begin m_req(0, 4'h1, 28'h100, 8'd0, 2'b01); m_req(0, 4'h2, 28'h200, 8'd0, 2'b01); end
      begin m_req(1, 4'h9, 28'h900, 8'd1, 2'b01); m_req(1, 4'hA, 28'hA00, 8'd0, 2'b01); end
      begin
        for (int k = 0; k < 4; k++) begin
          s_addr(1);
          s_data(int'(lens[k]) + 1, int'(lens[k]) + 1, ord[k], ids[k], 32'h2000_0000 + 32'(k * 16), 2'b00, 0);
        end
      end
    join

    // M0 alone, LEN=3, four beats, M1 stays silent
    snap_a = m1_vcnt;
    exp_gnt.push_back(0);
    exp_addr.push_back({4'h3, 28'h0000010, 8'd3, 2'b01});
    fork
      m_req(0, 4'h3, 28'h0000010, 8'd3, 2'b01);
      begin s_addr(1); s_data(4, 4, 0, 4'h3, 32'h1000_0000, 2'b01, 0); end
    join
    chk("t1_m1_silent", m1_vcnt - snap_a, 0);

    // slave holds address ready low for 5 cycles while M1 queues up behind
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    exp_addr.push_back({4'h4, 28'h0ABCDE0, 8'd0, 2'b01});
    exp_addr.push_back({4'h5, 28'h0000500, 8'd0, 2'b01});
    fork
      m_req(0, 4'h4, 28'h0ABCDE0, 8'd0, 2'b01);
      begin repeat (2) @(posedge clk); #1; m_req(1, 4'h5, 28'h0000500, 8'd0, 2'b01); end
      begin
        s_addr(5); s_data(1, 1, 0, 4'h4, 32'h3000_0000, 2'b00, 0);
        s_addr(1); s_data(1, 1, 1, 4'h5, 32'h3100_0000, 2'b00, 0);
      end
    join

    // LEN=7 but LAST on beat 5: SLVERR on beat 5
    exp_gnt.push_back(1);
    exp_addr.push_back({4'h8, 28'h0000800, 8'd7, 2'b01});
    fork
      m_req(1, 4'h8, 28'h0000800, 8'd7, 2'b01);
      begin s_addr(1); s_data(5, 5, 1, 4'h8, 32'h4000_0000, 2'b00, 5); end
    join
    S_RD_DATA_VALID = 1; #1;
    chk("idle_ignores_data", {S_RD_DATA_READY, M0_RD_DATA_VALID, M1_RD_DATA_VALID}, 0);
    S_RD_DATA_VALID = 0;
    @(posedge clk); #1;

    // LEN=1 with LAST only on beat 3: SLVERR on beat 2, beat 3 passes
    exp_gnt.push_back(0);
    exp_addr.push_back({4'h6, 28'h0000660, 8'd1, 2'b01});
    fork
      m_req(0, 4'h6, 28'h0000660, 8'd1, 2'b01);
      begin s_addr(1); s_data(3, 3, 0, 4'h6, 32'h4400_0000, 2'b01, 2); end
    join

    // M0 drops data ready for 3 cycles after beat 2
    snap_a = stall_cnt; snap_b = m0_beats;
    exp_gnt.push_back(0);
    exp_addr.push_back({4'h7, 28'h0000700, 8'd5, 2'b01});
    fork
      m_req(0, 4'h7, 28'h0000700, 8'd5, 2'b01);
      begin s_addr(1); s_data(6, 6, 0, 4'h7, 32'h5000_0000, 2'b00, 0); end
      begin
        trig_ok = 0;
        for (int i = 0; i < 400; i++) begin
          @(negedge clk); #1;
          if (m0_beats == snap_b + 2) begin trig_ok = 1; break; end
        end
        @(posedge clk); #1 M0_RD_DATA_READY = 0;
        repeat (3) @(posedge clk); #1 M0_RD_DATA_READY = 1;
        chk("stall_trigger", trig_ok, 1);
      end
    join
    chk("stall_cycles", stall_cnt - snap_a, 3);
    chk("stall_beats", m0_beats - snap_b, 6);

    // reset pulse on beat 2 of 8, then a fresh M1 request
    exp_gnt.push_back(0);
    exp_addr.push_back({4'hB, 28'h0000B00, 8'd7, 2'b01});
    fork
      m_req(0, 4'hB, 28'h0000B00, 8'd7, 2'b01);
      begin s_addr(1); s_data(1, 0, 0, 4'hB, 32'h6000_0000, 2'b00, 0); end
    join
    S_RD_BACK_ID = 4'hB; S_RD_DATA = 32'h6000_0002; S_RD_DATA_VALID = 1;
    rstn = 0; #2;
    chk("rst_mid_ctrl", {S_RD_ADDR_VALID, S_RD_DATA_READY, M0_RD_ADDR_READY, M1_RD_ADDR_READY,
                         M0_RD_DATA_VALID, M1_RD_DATA_VALID, M0_RD_DATA_LAST, M1_RD_DATA_LAST}, 0);
    chk("rst_mid_fields", {S_RD_ADDR_ID, S_RD_ADDR, S_RD_ADDR_LEN, S_RD_ADDR_BURST}, 0);
    exp_gnt.push_back(1);
    exp_addr.push_back({4'hC, 28'h0000C00, 8'd0, 2'b01});
    fork
      m_req(1, 4'hC, 28'h0000C00, 8'd0, 2'b01);
      begin
        @(posedge clk); #1 S_RD_DATA_VALID = 0;
        repeat (2) @(negedge clk);
        chk("rst_hold_ctrl", {M0_RD_ADDR_READY, M1_RD_ADDR_READY, S_RD_ADDR_VALID,
                              S_RD_DATA_READY, M0_RD_DATA_VALID}, 0);
        @(posedge clk); #1 rstn = 1;
      end
      begin s_addr(1); s_data(1, 1, 1, 4'hC, 32'h7000_0000, 2'b00, 0); end
    join

    repeat (3) @(posedge clk); #1;
    chk("scoreboard_drained", q0.size() + q1.size() + exp_addr.size() + exp_gnt.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
